// File: rtl/uart_tx_ctrl.sv
// ============================================================================
// Module   : uart_tx_ctrl
// Purpose  : UART transmit frame controller (start, LSB-first data, optional
//            parity, stop) driving the serializer and a registered TX line.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module uart_tx_ctrl #(
    parameter int WIDTH_DATA = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [WIDTH_DATA-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  ser_done,
    input  logic                  ser_data,
    output logic                  ser_en,
    output logic [WIDTH_DATA-1:0] DATA_HELD,
    output logic                  TX_OUT,
    output logic                  BUSY
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]            r_state;
    logic [2:0]            w_next;
    logic                  w_accept;
    logic [WIDTH_DATA-1:0] r_data_held;
    logic                  r_par_en;
    logic                  r_par_typ;
    logic                  w_parity;
    logic                  w_line;
    logic                  r_tx;

    // Requests are taken only when idle or in the final stop cycle, so no queueing.
    assign w_accept = DATA_VALID && ((r_state == S_IDLE) || (r_state == S_STOP));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = w_accept ? S_START : S_IDLE;
            S_START:  w_next = S_DATA;
            S_DATA:   begin
                if (ser_done) begin
                    w_next = r_par_en ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: w_next = S_STOP;
            S_STOP:   w_next = w_accept ? S_START : S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_data_held <= '0;
            r_par_en    <= 1'b0;
            r_par_typ   <= 1'b0;
        end else if (w_accept) begin
            r_data_held <= P_DATA;
            r_par_en    <= PAR_EN;
            r_par_typ   <= PAR_TYP;
        end
    end

    assign w_parity = r_par_typ ? ~^r_data_held : ^r_data_held;

    always_comb begin
        ser_en = 1'b0;
        BUSY   = 1'b1;
        w_line = 1'b1;
        case (r_state)
            S_IDLE:   BUSY = 1'b0;
            S_START:  w_line = 1'b0;
            S_DATA:   begin
                ser_en = 1'b1;
                w_line = ser_data;
            end
            S_PARITY: w_line = w_parity;
            S_STOP:   w_line = 1'b1;
            default:  begin
                BUSY   = 1'b0;
                w_line = 1'b1;
            end
        endcase
    end

    // Registering the mux gives every state the same one-cycle delay to the line.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_tx <= 1'b1;
        end else begin
            r_tx <= w_line;
        end
    end

    assign TX_OUT    = r_tx;
    assign DATA_HELD = r_data_held;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
// ============================================================================
// Module   : tb_uart_tx_ctrl
// Purpose  : Self-checking bench for uart_tx_ctrl with a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_tx_ctrl;

    localparam int W = 8;
    localparam logic [2:0] LAST = 3'(W - 1);

    logic         CLK = 1'b0;
    logic         RST;
    logic [W-1:0] P_DATA;
    logic         DATA_VALID;
    logic         PAR_EN;
    logic         PAR_TYP;
    logic         ser_done;
    logic         ser_data;
    logic         ser_en;
    logic [W-1:0] DATA_HELD;
    logic         TX_OUT;
    logic         BUSY;

    uart_tx_ctrl #(.WIDTH_DATA(W)) u_dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .ser_done   (ser_done),
        .ser_data   (ser_data),
        .ser_en     (ser_en),
        .DATA_HELD  (DATA_HELD),
        .TX_OUT     (TX_OUT),
        .BUSY       (BUSY)
    );

    always #5 CLK = ~CLK;

    // Behavioural serializer: counter from zero, done on the last bit; noisy done outside DATA.
    logic [2:0] r_cnt;
    logic       r_noise;
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_cnt <= '0;
        end else if (ser_en && !ser_done) begin
            r_cnt <= r_cnt + 3'd1;
        end else begin
            r_cnt <= '0;
        end
    end
    assign ser_data = ser_en ? DATA_HELD[r_cnt] : 1'b0;
    assign ser_done = ser_en ? (r_cnt == LAST) : r_noise;

    int n_chk = 0;
    int n_err = 0;

    // Model state: expected line bits still to appear, cycles left in frame.
    bit           m_q[$];
    int           m_left = 0;
    int           m_len  = 0;
    logic [W-1:0] m_held = '0;
    logic         e_tx;
    logic         e_en;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic model_step(input logic dv, input logic [W-1:0] d,
                              input logic pe, input logic pt);
        int ones;
        int pos;
        e_tx = (m_q.size() > 0) ? m_q.pop_front() : 1'b1;
        if (dv && (m_left == 0 || m_left == 1)) begin
            ones = $countones(d);
            m_q.push_back(1'b0);
            for (int i = 0; i < W; i++) m_q.push_back(d[i]);
            if (pe) m_q.push_back(pt ? (ones % 2 == 0) : (ones % 2 == 1));
            m_q.push_back(1'b1);
            m_len  = W + 2 + (pe ? 1 : 0);
            m_left = m_len;
            m_held = d;
        end else if (m_left > 0) begin
            m_left--;
        end
        pos  = m_len - m_left;
        e_en = (m_left > 0) && (pos >= 1) && (pos <= W);
    endtask

    task automatic check_outputs();
        chk("tx_out", 32'(TX_OUT), 32'(e_tx));
        chk("busy", 32'(BUSY), 32'(m_left != 0));
        chk("ser_en", 32'(ser_en), 32'(e_en));
        chk("data_held", 32'(DATA_HELD), 32'(m_held));
    endtask

    task automatic cycle(input logic dv, input logic [W-1:0] d,
                         input logic pe, input logic pt);
        @(negedge CLK);
        DATA_VALID = dv;
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        r_noise    = 1'($urandom_range(0, 1));
        @(posedge CLK);
        model_step(dv, d, pe, pt);
        #1;
        check_outputs();
    endtask

    task automatic frame(input logic [W-1:0] d, input logic pe, input logic pt, input int tail);
        cycle(1'b1, d, pe, pt);
        for (int i = 0; i < tail; i++) cycle(1'b0, W'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic model_reset();
        m_q.delete();
        m_left = 0;
        m_len  = 0;
        m_held = '0;
        e_tx   = 1'b1;
        e_en   = 1'b0;
    endtask

    initial begin
        RST        = 1'b0;
        DATA_VALID = 1'b0;
        P_DATA     = '0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        r_noise    = 1'b0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check_outputs();
        @(negedge CLK);
        RST = 1'b1;

        frame(8'hA5, 1'b1, 1'b0, 13);
        frame(8'h01, 1'b1, 1'b1, 13);
        frame(8'hFF, 1'b0, 1'b0, 12);

        // Back-to-back: request exactly while the first frame sits in STOP.
        cycle(1'b1, 8'h3C, 1'b1, 1'b0);
        for (int i = 0; i < 30; i++) begin
            if (m_left == 1 && m_held == 8'h3C) cycle(1'b1, 8'hC3, 1'b0, 1'b1);
            else cycle(1'b0, 8'h00, 1'b0, 1'b0);
        end

        // Request pulsed mid-DATA must be ignored.
        cycle(1'b1, 8'h55, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) cycle(i == 4, 8'h00, 1'b1, 1'b1);

        // Asynchronous reset mid-DATA, then a fresh frame.
        cycle(1'b1, 8'h96, 1'b1, 1'b0);
        repeat (4) cycle(1'b0, 8'h00, 1'b0, 1'b0);
        #2;
        RST = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge CLK);
        #1;
        check_outputs();
        @(negedge CLK);
        RST = 1'b1;
        frame(8'h6B, 1'b1, 1'b1, 13);

        // Random traffic, including requests at arbitrary points in a frame.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 3) == 0), W'($urandom), 1'($urandom), 1'($urandom));
        end
        repeat (14) cycle(1'b0, 8'h00, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

`default_nettype wire
